// File: rtl/spk_pkg.sv
// Shared flit type codes, arbiter state encoding and type classification helpers
// for the node-ingress spike arbiter.
package spk_pkg;

    localparam logic [2:0] SPIKE    = 3'b000;
    localparam logic [2:0] DATA     = 3'b001;
    localparam logic [2:0] DATA_END = 3'b010;
    localparam logic [2:0] WRITE    = 3'b110;
    localparam logic [2:0] READ     = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        AXON,
        CONFIG,
        DROP
    } state_t;

    function automatic logic is_axon_type(input logic [2:0] t);
        return (t == SPIKE) || (t == DATA) || (t == DATA_END);
    endfunction

    function automatic logic is_cfg_type(input logic [2:0] t);
        return (t == WRITE) || (t == READ);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting port after 'last',
// wrapping around, returned both one-hot and as an index.
module rr_pick #(
    parameter int NP = 4,
    parameter int PW = 2
) (
    input  logic [NP-1:0] req,
    input  logic [PW-1:0] last,
    output logic [NP-1:0] gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic found;

    // Ports above 'last' outrank ports at or below it; lowest index wins within each group.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int j = 0; j < NP; j++) begin
            if (!found && req[j] && (PW'(j) > last)) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
        for (int j = 0; j < NP; j++) begin
            if (!found && req[j] && (PW'(j) <= last)) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/spk_in_arb.sv
// Round-robin ingress scheduler sharing one axon and one config interface among NP spike FIFOs.
// Define SPK_IN_ARB_STAT_EN to enable the saturating illegal-flit drop counter on drop_cnt.
module spk_in_arb
    import spk_pkg::*;
#(
    parameter int NP  = 4,
    parameter int PW  = 2,
    parameter int FW  = 59,
    parameter int FTW = 3,
    parameter int SW  = 24
) (
    input  logic             clk_spk_in,
    input  logic             rst,
    input  logic [NP-1:0]    src_empty,
    input  logic [NP*FW-1:0] src_data,
    output logic [NP-1:0]    src_pop,
    input  logic             axon_busy,
    output logic             axon_vld,
    output logic [SW-1:0]    axon_data,
    output logic [FTW-1:0]   axon_type,
    output logic [PW-1:0]    axon_src,
    input  logic             config_credit,
    output logic             config_we,
    output logic [FW-1:0]    config_wdata,
    output logic [PW-1:0]    config_src,
    output logic [7:0]       drop_cnt
);

    state_t         state;
    logic [PW-1:0]  gnt_idx, rr_last, lock_port, pick_idx;
    logic [NP-1:0]  gnt_oh, req, pick_gnt;
    logic           lock, credit, pick_any;
    logic [FW-1:0]  head;
    logic [FTW-1:0] head_type;
    logic           head_axon, head_cfg, leave;

    // While a DATA burst is open only its port may compete, keeping the burst atomic.
    always_comb begin
        req = '0;
        for (int p = 0; p < NP; p++) begin
            req[p] = !src_empty[p] && (!lock || (PW'(p) == lock_port));
        end
    end

    rr_pick #(.NP(NP), .PW(PW)) u_pick (
        .req  (req),
        .last (rr_last),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        head = '0;
        for (int p = 0; p < NP; p++) begin
            if (PW'(p) == gnt_idx) head = src_data[p*FW +: FW];
        end
        head_type = head[FW-1 -: FTW];
        head_axon = is_axon_type(head_type);
        head_cfg  = is_cfg_type(head_type);
        leave     = (state == WAIT) &&
                    (head_axon ? !axon_busy : (head_cfg ? credit : 1'b1));
    end

    assign src_pop   = leave ? gnt_oh : '0;
    assign axon_vld  = (state == AXON);
    assign config_we = (state == CONFIG);

    always_ff @(posedge clk_spk_in or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            gnt_idx      <= '0;
            gnt_oh       <= '0;
            rr_last      <= PW'(NP - 1);
            lock         <= 1'b0;
            lock_port    <= '0;
            credit       <= 1'b1;
            axon_data    <= '0;
            axon_type    <= '0;
            axon_src     <= '0;
            config_wdata <= '0;
            config_src   <= '0;
        end else begin
            // A returning credit in the same cycle as a write strobe leaves credit available.
            if (config_credit)         credit <= 1'b1;
            else if (state == CONFIG)  credit <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_idx <= pick_idx;
                        gnt_oh  <= pick_gnt;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (leave) begin
                        rr_last <= gnt_idx;
                        if (head_axon) begin
                            state     <= AXON;
                            axon_data <= head[SW-1:0];
                            axon_type <= head_type;
                            axon_src  <= gnt_idx;
                            if (head_type == DATA) begin
                                lock      <= 1'b1;
                                lock_port <= gnt_idx;
                            end else if (head_type == DATA_END && gnt_idx == lock_port) begin
                                lock <= 1'b0;
                            end
                        end else if (head_cfg) begin
                            state        <= CONFIG;
                            config_wdata <= head;
                            config_src   <= gnt_idx;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPK_IN_ARB_STAT_EN
    always_ff @(posedge clk_spk_in or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (state == DROP && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_spk_in_arb.sv
// Self-checking bench for spk_in_arb: directed latency/busy/reset cases plus randomized
// preloaded-FIFO rounds checked against a transaction-level arbitration model.
module tb_spk_in_arb;

    localparam int NP  = 4;
    localparam int PW  = 2;
    localparam int FW  = 59;
    localparam int FTW = 3;
    localparam int SW  = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    src_empty;
    logic [NP*FW-1:0] src_data;
    logic [NP-1:0]    src_pop;
    logic             axon_busy;
    logic             axon_vld;
    logic [SW-1:0]    axon_data;
    logic [FTW-1:0]   axon_type;
    logic [PW-1:0]    axon_src;
    logic             config_credit;
    logic             config_we;
    logic [FW-1:0]    config_wdata;
    logic [PW-1:0]    config_src;
    logic [7:0]       drop_cnt;

    spk_in_arb #(.NP(NP), .PW(PW), .FW(FW), .FTW(FTW), .SW(SW)) dut (
        .clk_spk_in    (clk),
        .rst           (rst),
        .src_empty     (src_empty),
        .src_data      (src_data),
        .src_pop       (src_pop),
        .axon_busy     (axon_busy),
        .axon_vld      (axon_vld),
        .axon_data     (axon_data),
        .axon_type     (axon_type),
        .axon_src      (axon_src),
        .config_credit (config_credit),
        .config_we     (config_we),
        .config_wdata  (config_wdata),
        .config_src    (config_src),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // FIFO emulation: per-port storage with read/write pointers
    logic [FW-1:0] mem [NP][64];
    int rd_ptr [NP];
    int wr_ptr [NP];

    always_comb begin
        src_empty = '0;
        src_data  = '0;
        for (int p = 0; p < NP; p++) begin
            src_empty[p]          = (rd_ptr[p] == wr_ptr[p]);
            src_data[p*FW +: FW]  = mem[p][rd_ptr[p] % 64];
        end
    end

    always @(posedge clk or posedge rst) begin
        for (int p = 0; p < NP; p++) begin
            if (rst)             rd_ptr[p] <= 0;
            else if (src_pop[p]) rd_ptr[p] <= rd_ptr[p] + 1;
        end
    end

    // Expected issue sequence and monitor state
    int            exp_port [256];
    logic [FW-1:0] exp_flit [256];
    int            n_exp, k, drops;
    int            pend_kind;
    logic [FW-1:0] pend_flit;
    int            pend_port;
    bit            model_credit;
    bit            mon_en;
    bit            cfg_now;
    int            pidx;
    logic [2:0]    ptype;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [FW-1:0] makeFlit(input logic [2:0] t);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return {t, r[FW-4:0]};
    endfunction

    task automatic pushFlit(input int p, input logic [FW-1:0] f);
        mem[p][wr_ptr[p]] = f;
        wr_ptr[p]++;
    endtask

    task automatic applyReset();
        rst           = 1'b1;
        axon_busy     = 1'b0;
        config_credit = 1'b0;
        mon_en        = 1'b0;
        pend_kind     = 0;
        k             = 0;
        n_exp         = 0;
        drops         = 0;
        model_credit  = 1'b1;
        for (int p = 0; p < NP; p++) wr_ptr[p] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Random well-formed per-port streams: spikes, atomic bursts, config and illegal flits
    task automatic fillPorts();
        int items, kind, n;
        for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 4) == 0) continue;
            items = $urandom_range(1, 4);
            for (int it = 0; it < items; it++) begin
                kind = $urandom_range(0, 5);
                case (kind)
                    0, 1: pushFlit(p, makeFlit(3'b000));
                    2: begin
                        n = $urandom_range(1, 3);
                        for (int d = 0; d < n; d++) pushFlit(p, makeFlit(3'b001));
                        pushFlit(p, makeFlit(3'b010));
                    end
                    3: pushFlit(p, makeFlit(3'b110));
                    4: pushFlit(p, makeFlit(3'b111));
                    default: pushFlit(p, makeFlit(3'($urandom_range(3, 5))));
                endcase
            end
        end
    endtask

    // Order in which flits leave the FIFOs, derived from the scheduling rules alone
    task automatic buildModel();
        int rd [NP];
        int rr, lp, pick, p;
        bit lock, done;
        logic [2:0] t;
        for (int i = 0; i < NP; i++) rd[i] = 0;
        rr = NP - 1; lock = 0; lp = 0; done = 0;
        n_exp = 0; drops = 0;
        while (!done) begin
            pick = -1;
            for (int off = 1; off <= NP; off++) begin
                p = (rr + off) % NP;
                if (pick < 0 && rd[p] < wr_ptr[p] && (!lock || p == lp)) pick = p;
            end
            if (pick < 0) begin
                done = 1;
            end else begin
                exp_port[n_exp] = pick;
                exp_flit[n_exp] = mem[pick][rd[pick]];
                t = exp_flit[n_exp][FW-1 -: 3];
                rd[pick]++;
                n_exp++;
                if (t == 3'b001) begin
                    lock = 1; lp = pick;
                end else if (t == 3'b010 && lock && lp == pick) begin
                    lock = 0;
                end else if (t inside {3'b011, 3'b100, 3'b101}) begin
                    drops++;
                end
                rr = pick;
            end
        end
    endtask

    task automatic applyStimulus(input int busy_pct, input int credit_pct);
        int cyc;
        int exp_drop;
        applyReset();
        fillPorts();
        buildModel();
        mon_en = 1'b1;
        cyc = 0;
        while (k < n_exp && cyc < 3000) begin
            @(posedge clk);
            #1;
            axon_busy     = ($urandom_range(0, 99) < busy_pct);
            config_credit = ($urandom_range(0, 99) < credit_pct);
            cyc++;
        end
        axon_busy     = 1'b0;
        config_credit = 1'b0;
        repeat (3) @(posedge clk);
        #1 mon_en = 1'b0;
        checkOutput("all_issued", k, n_exp);
        checkOutput("drained", src_empty, {NP{1'b1}});
`ifdef SPK_IN_ARB_STAT_EN
        exp_drop = (drops > 255) ? 255 : drops;
`else
        exp_drop = 0;
`endif
        checkOutput("drop_cnt", drop_cnt, exp_drop);
    endtask

    // Monitor: strobes follow pops by one cycle; pops follow the model order and gating rules
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                cfg_now = (pend_kind == 2);
                if (pend_kind != 0 || axon_vld || config_we) begin
                    checkOutput("axon_vld", axon_vld, pend_kind == 1);
                    checkOutput("config_we", config_we, pend_kind == 2);
                    if (pend_kind == 1) begin
                        checkOutput("axon_data", axon_data, pend_flit[SW-1:0]);
                        checkOutput("axon_type", axon_type, pend_flit[FW-1 -: FTW]);
                        checkOutput("axon_src", axon_src, pend_port);
                    end
                    if (pend_kind == 2) begin
                        checkOutput("config_wdata", config_wdata, pend_flit);
                        checkOutput("config_src", config_src, pend_port);
                    end
                end
                pend_kind = 0;
                if (src_pop != '0) begin
                    checkOutput("pop_onehot", $countones(src_pop), 1);
                    pidx = 0;
                    for (int p = 0; p < NP; p++) if (src_pop[p]) pidx = p;
                    if (k < n_exp) begin
                        checkOutput("pop_port", pidx, exp_port[k]);
                        ptype = exp_flit[k][FW-1 -: 3];
                        if (ptype inside {3'b000, 3'b001, 3'b010}) begin
                            pend_kind = 1;
                            checkOutput("pop_while_busy", axon_busy, 0);
                        end else if (ptype inside {3'b110, 3'b111}) begin
                            pend_kind = 2;
                            checkOutput("pop_without_credit", model_credit, 1);
                        end else begin
                            pend_kind = 3;
                        end
                        pend_flit = exp_flit[k];
                        pend_port = exp_port[k];
                        k++;
                    end else begin
                        checkOutput("pop_extra", k + 1, n_exp);
                    end
                end
                if (config_credit) model_credit = 1'b1;
                else if (cfg_now)  model_credit = 1'b0;
            end
        end
    end

    logic [FW-1:0] f_spike, f_write;

    initial begin
        for (int p = 0; p < NP; p++) begin
            rd_ptr[p] = 0;
            wr_ptr[p] = 0;
        end
        applyReset();

        // Reset state
        @(negedge clk);
        checkOutput("rst_pop", src_pop, 0);
        checkOutput("rst_axon_vld", axon_vld, 0);
        checkOutput("rst_config_we", config_we, 0);
        checkOutput("rst_axon_data", axon_data, 0);
        checkOutput("rst_config_wdata", config_wdata, 0);
        checkOutput("rst_drop_cnt", drop_cnt, 0);

        // Single spike latency: pop one cycle after it appears, strobe one cycle later
        @(posedge clk);
        #1 pushFlit(0, {3'b000, 32'h0, 24'h123456});
        @(negedge clk);
        checkOutput("lat_c0_pop", src_pop, 0);
        @(negedge clk);
        checkOutput("lat_c1_pop", src_pop, 4'b0001);
        checkOutput("lat_c1_vld", axon_vld, 0);
        @(negedge clk);
        checkOutput("lat_c2_vld", axon_vld, 1);
        checkOutput("lat_c2_data", axon_data, 24'h123456);
        checkOutput("lat_c2_type", axon_type, 3'b000);
        checkOutput("lat_c2_src", axon_src, 0);
        checkOutput("lat_c2_pop", src_pop, 0);

        // Axon busy holds the grant without popping
        @(posedge clk);
        #1;
        axon_busy = 1'b1;
        pushFlit(2, {3'b000, 32'h0, 24'hABCDEF});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("busy_hold_pop", src_pop, 0);
        end
        @(posedge clk);
        #1 axon_busy = 1'b0;
        @(negedge clk);
        checkOutput("busy_release_pop", src_pop, 4'b0100);
        @(negedge clk);
        checkOutput("busy_release_vld", axon_vld, 1);
        checkOutput("busy_release_src", axon_src, 2);
        checkOutput("busy_release_data", axon_data, 24'hABCDEF);

        // Reset while a grant waits in WAIT clears every output register
        applyReset();
        f_write = makeFlit(3'b110);
        f_spike = makeFlit(3'b000);
        pushFlit(1, f_write);
        pushFlit(1, f_spike);
        repeat (8) @(negedge clk);
        checkOutput("pre_rst_config_src", config_src, 1);
        checkOutput("pre_rst_config_wdata", config_wdata, f_write);
        checkOutput("pre_rst_axon_data", axon_data, f_spike[SW-1:0]);
        @(posedge clk);
        #1;
        axon_busy = 1'b1;
        pushFlit(2, makeFlit(3'b000));
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int p = 0; p < NP; p++) wr_ptr[p] = 0;
        @(negedge clk);
        checkOutput("mid_rst_pop", src_pop, 0);
        checkOutput("mid_rst_axon_vld", axon_vld, 0);
        checkOutput("mid_rst_axon_data", axon_data, 0);
        checkOutput("mid_rst_axon_src", axon_src, 0);
        checkOutput("mid_rst_config_wdata", config_wdata, 0);
        checkOutput("mid_rst_config_src", config_src, 0);

        // Randomized rounds with varying backpressure and credit return rates
        for (int r = 0; r < 12; r++) begin
            applyStimulus((r % 3) * 30, 10 + (r % 4) * 25);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
